plic_gateway: RTL and testbench



---
 rtl/plic_gateway_pkg.sv | 24 ++
 rtl/plic_gw_chan.sv | 112 +++++++++++
 rtl/plic_gateway.sv | 124 ++++++++++++
 tb/tb_plic_gateway.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_gateway_pkg.sv
// Shared definitions for the PLIC interrupt gateway: bus widths,
// register offsets and channel state encodings.
package plic_gateway_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_W      = 32;
  localparam int NSRC       = 16;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_bus_t;
  typedef logic [MEM_W-1:0]      mem_bus_t;

  localparam logic [7:0] GW_EN_OFS   = 8'h00;
  localparam logic [7:0] GW_MODE_OFS = 8'h04;
  localparam logic [7:0] GW_CMP_OFS  = 8'h08;
  localparam logic [7:0] GW_STAT_OFS = 8'h0C;
  localparam logic [7:0] GW_CNT_OFS  = 8'h10;

  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_REQ  = 2'd1,
    GW_WAIT = 2'd2
  } gw_state_e;

endpackage

// File: rtl/plic_gw_chan.sv
// One gateway channel: synchroniser, edge detect, request FSM and
// saturating queue counter for pending edge triggers.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   GW_IDLE | no request outstanding, waiting for a trigger
//   GW_REQ  | request presented to the PLIC, waiting for a claim
//   GW_WAIT | claimed, waiting for software completion
module plic_gw_chan
  import plic_gateway_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_raw_i,
  input  logic       en_i,
  input  logic       mode_i,
  input  logic       mode_chg_i,
  input  logic       claim_i,
  input  logic       cmp_i,
  output logic       irq_o,
  output logic       wait_o,
  output logic [1:0] cnt_o
);

  logic      sync1_q, sync1_d;
  logic      sync2_q, sync2_d;
  logic      sync_dly_q, sync_dly_d;
  gw_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic      edge_w;
  logic      inc_w;
  logic      dec_w;

  assign edge_w = sync2_q & ~sync_dly_q;

  // Two-flop synchroniser followed by the delayed copy used for edge detect
  always_comb begin
    sync1_d    = irq_raw_i;
    sync2_d    = sync1_q;
    sync_dly_d = sync2_q;
  end

  // Synchroniser registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync_dly_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync_dly_q <= sync_dly_d;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GW_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a disabled channel is held in IDLE
  always_comb begin
    state_d = state_q;
    dec_w   = 1'b0;
    if (!en_i) begin
      state_d = GW_IDLE;
    end else begin
      case (state_q)
        GW_IDLE: if (mode_i ? edge_w : sync2_q) state_d = GW_REQ;
        GW_REQ:  if (claim_i) state_d = GW_WAIT;
        GW_WAIT: begin
          if (cmp_i) begin
            if (mode_i && (cnt_q != 2'd0)) begin
              state_d = GW_REQ;
              dec_w   = 1'b1;
            end else begin
              state_d = GW_IDLE;
            end
          end
        end
        default: state_d = GW_IDLE;
      endcase
    end
  end

  // Queue counter: edges during REQ/WAIT count up, re-raised requests count down
  always_comb begin
    inc_w = edge_w & ((state_q == GW_REQ) | (state_q == GW_WAIT));
    cnt_d = cnt_q;
    if (!en_i || mode_chg_i) begin
      cnt_d = 2'd0;
    end else if (inc_w && !dec_w) begin
      cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
    end else if (dec_w && !inc_w) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    irq_o  = (state_q == GW_REQ);
    wait_o = (state_q == GW_WAIT);
    cnt_o  = cnt_q;
  end

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway top: ICB register slave, configuration
// registers, readback mux and fifteen per-source channels.
module plic_gateway
  import plic_gateway_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gw_icb_cmd_valid,
  output logic                  gw_icb_cmd_ready,
  input  logic [MEM_ADDR_W-1:0] gw_icb_cmd_addr,
  input  logic                  gw_icb_cmd_read,
  input  logic [MEM_W-1:0]      gw_icb_cmd_wdata,
  input  logic [3:0]            gw_icb_cmd_wmask,
  output logic                  gw_icb_rsp_valid,
  input  logic                  gw_icb_rsp_ready,
  output logic                  gw_icb_rsp_err,
  output logic [MEM_W-1:0]      gw_icb_rsp_rdata,
  input  logic [NSRC-1:0]       irq_src_i,
  output logic [NSRC-1:0]       gw_irq_o,
  input  logic                  claim_valid_i,
  input  logic [4:0]            claim_id_i
);

  logic [15:1]     en_q, en_d;
  logic [15:1]     mode_q, mode_d;
  logic [4:0]      cmp_q, cmp_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [MEM_W-1:0] rdata_q, rdata_d;
  logic [MEM_W-1:0] rb_w;
  logic [15:1]     mode_chg_w;
  logic [15:1]     irq_w;
  logic [15:1]     wait_w;
  logic [29:0]     cnt_w;
  logic            wr_w, rd_w, cmp_hit_w;
  logic [7:0]      ofs_w;
  logic            unused_ok;

  assign wr_w      = gw_icb_cmd_valid & ~gw_icb_cmd_read;
  assign rd_w      = gw_icb_cmd_valid &  gw_icb_cmd_read;
  assign ofs_w     = gw_icb_cmd_addr[7:0];
  assign cmp_hit_w = wr_w & (ofs_w == GW_CMP_OFS);
  assign unused_ok = ^{gw_icb_cmd_wmask, gw_icb_cmd_addr[MEM_ADDR_W-1:8],
                       gw_icb_cmd_wdata[MEM_W-1:16], irq_src_i[0]};

  assign gw_icb_cmd_ready = 1'b1;
  assign gw_icb_rsp_err   = 1'b0;
  assign gw_icb_rsp_valid = rsp_valid_q;
  assign gw_icb_rsp_rdata = rdata_q;
  assign gw_irq_o         = {irq_w, 1'b0};

  // Configuration register updates; mode changes are flagged per bit
  always_comb begin
    en_d       = en_q;
    mode_d     = mode_q;
    cmp_d      = cmp_q;
    mode_chg_w = '0;
    if (wr_w && (ofs_w == GW_EN_OFS))   en_d = gw_icb_cmd_wdata[15:1];
    if (wr_w && (ofs_w == GW_MODE_OFS)) begin
      mode_d     = gw_icb_cmd_wdata[15:1];
      mode_chg_w = gw_icb_cmd_wdata[15:1] ^ mode_q;
    end
    if (cmp_hit_w) cmp_d = gw_icb_cmd_wdata[4:0];
  end

  // Readback mux over the current register and channel state
  always_comb begin
    rb_w = '0;
    case (ofs_w)
      GW_EN_OFS:   rb_w = {16'b0, en_q, 1'b0};
      GW_MODE_OFS: rb_w = {16'b0, mode_q, 1'b0};
      GW_CMP_OFS:  rb_w = {27'b0, cmp_q};
      GW_STAT_OFS: rb_w = {irq_w, 1'b0, wait_w, 1'b0};
      GW_CNT_OFS:  rb_w = {2'b0, cnt_w};
      default:     rb_w = '0;
    endcase
  end

  // Read response: a new read always refreshes data, otherwise hold until accepted
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    if (rd_w) begin
      rsp_valid_d = 1'b1;
      rdata_d     = rb_w;
    end else if (rsp_valid_q && gw_icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= '0;
      mode_q      <= '0;
      cmp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      en_q        <= en_d;
      mode_q      <= mode_d;
      cmp_q       <= cmp_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Channels see the post-write configuration so a write acts at its own edge
  for (genvar g = 1; g < NSRC; g++) begin : g_chan
    plic_gw_chan u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_raw_i  (irq_src_i[g]),
      .en_i       (en_d[g]),
      .mode_i     (mode_d[g]),
      .mode_chg_i (mode_chg_w[g]),
      .claim_i    (claim_valid_i && (claim_id_i == 5'(g))),
      .cmp_i      (cmp_hit_w && (gw_icb_cmd_wdata[4:0] == 5'(g))),
      .irq_o      (irq_w[g]),
      .wait_o     (wait_w[g]),
      .cnt_o      (cnt_w[2*(g-1) +: 2])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway with a behavioural reference model.
module tb_plic_gateway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] irq_src, gw_irq;
  logic        claim_valid;
  logic [4:0]  claim_id;

  int checks = 0;
  int errors = 0;

  plic_gateway dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .gw_icb_cmd_valid (cmd_valid),
    .gw_icb_cmd_ready (cmd_ready),
    .gw_icb_cmd_addr  (cmd_addr),
    .gw_icb_cmd_read  (cmd_read),
    .gw_icb_cmd_wdata (cmd_wdata),
    .gw_icb_cmd_wmask (cmd_wmask),
    .gw_icb_rsp_valid (rsp_valid),
    .gw_icb_rsp_ready (rsp_ready),
    .gw_icb_rsp_err   (rsp_err),
    .gw_icb_rsp_rdata (rsp_rdata),
    .irq_src_i        (irq_src),
    .gw_irq_o         (gw_irq),
    .claim_valid_i    (claim_valid),
    .claim_id_i       (claim_id)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [15:0] m_s1, m_s2, m_sd;   // synchroniser pipeline
  bit [15:0] m_pending;          // request presented to PLIC
  bit [15:0] m_claimed;          // waiting for completion
  int        m_cnt [16];
  bit [15:0] m_en, m_mode;
  bit [4:0]  m_cmp;
  bit        m_rv;
  bit [31:0] m_rdata;

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_sd = '0;
    m_pending = '0; m_claimed = '0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_en = '0; m_mode = '0; m_cmp = '0;
    m_rv = 1'b0; m_rdata = '0;
  endtask

  function automatic bit [31:0] m_readback(bit [7:0] a);
    bit [31:0] r;
    r = '0;
    for (int i = 1; i < 16; i++) begin
      case (a)
        8'h00: r[i] = m_en[i];
        8'h04: r[i] = m_mode[i];
        8'h0C: begin r[i] = m_claimed[i]; r[16+i] = m_pending[i]; end
        8'h10: r[2*(i-1) +: 2] = 2'(m_cnt[i]);
        default: ;
      endcase
    end
    if (a == 8'h08) r = {27'b0, m_cmp};
    return r;
  endfunction

  task automatic m_step();
    bit wr, rd, edge_seen, mchg, claim, cmp, inc, dec;
    bit [7:0]  a;
    bit [15:0] en_n, mode_n;
    bit [31:0] rb;
    wr = cmd_valid && !cmd_read;
    rd = cmd_valid && cmd_read;
    a  = cmd_addr[7:0];
    en_n   = (wr && a == 8'h00) ? {cmd_wdata[15:1], 1'b0} : m_en;
    mode_n = (wr && a == 8'h04) ? {cmd_wdata[15:1], 1'b0} : m_mode;
    rb = m_readback(a);
    for (int i = 1; i < 16; i++) begin
      edge_seen = m_s2[i] && !m_sd[i];
      mchg  = wr && a == 8'h04 && (cmd_wdata[i] != m_mode[i]);
      claim = claim_valid && claim_id == 5'(i);
      cmp   = wr && a == 8'h08 && cmd_wdata[4:0] == 5'(i);
      inc   = edge_seen && (m_pending[i] || m_claimed[i]);
      dec   = 1'b0;
      if (!en_n[i]) begin
        m_pending[i] = 1'b0;
        m_claimed[i] = 1'b0;
        m_cnt[i] = 0;
      end else begin
        if (m_pending[i]) begin
          if (claim) begin m_pending[i] = 1'b0; m_claimed[i] = 1'b1; end
        end else if (m_claimed[i]) begin
          if (cmp) begin
            m_claimed[i] = 1'b0;
            if (mode_n[i] && m_cnt[i] > 0) begin m_pending[i] = 1'b1; dec = 1'b1; end
          end
        end else begin
          m_pending[i] = mode_n[i] ? edge_seen : m_s2[i];
        end
        if (mchg) m_cnt[i] = 0;
        else if (inc && !dec) m_cnt[i] = (m_cnt[i] >= 3) ? 3 : m_cnt[i] + 1;
        else if (dec && !inc) m_cnt[i] = m_cnt[i] - 1;
      end
    end
    m_sd = m_s2; m_s2 = m_s1; m_s1 = irq_src;
    m_en = en_n; m_mode = mode_n;
    if (wr && a == 8'h08) m_cmp = cmd_wdata[4:0];
    if (rd) begin m_rv = 1'b1; m_rdata = rb; end
    else if (m_rv && rsp_ready) m_rv = 1'b0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_read = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = 4'hF;
    rsp_ready = 1; irq_src = '0; claim_valid = 0; claim_id = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
  endtask

  task automatic icb_write(input bit [7:0] a, input bit [31:0] d);
    cmd_valid = 1; cmd_read = 0; cmd_addr = {24'h0, a}; cmd_wdata = d;
    tick();
    cmd_valid = 0;
  endtask

  task automatic icb_read(input bit [7:0] a, output bit [31:0] d, output bit v);
    cmd_valid = 1; cmd_read = 1; cmd_addr = {24'h0, a};
    tick();
    cmd_valid = 0; cmd_read = 0;
    d = rsp_rdata; v = rsp_valid;
  endtask

  task automatic do_claim(input int id);
    claim_valid = 1; claim_id = 5'(id);
    tick();
    claim_valid = 0;
  endtask

  task automatic pulse(input int ch);
    irq_src[ch] = 1; tick(); tick();
    irq_src[ch] = 0; tick(); tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    checks++;
    if (gw_irq !== 16'h0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%h rsp_valid=%b rdata=%h, need 0/0/0", gw_irq, rsp_valid, rsp_rdata);
    end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ties: cmd_ready=%b rsp_err=%b, need 1/0", cmd_ready, rsp_err);
    end
    do_reset();
  endtask

  task automatic test_level();
    bit [31:0] d; bit v;
    do_reset();
    icb_write(8'h00, 32'h1 << 3);
    irq_src[3] = 1;
    tick(); tick();
    checks++;
    if (gw_irq[3] !== 1'b0) begin errors++; $display("FAIL level_early: irq3=%b need 0", gw_irq[3]); end
    tick();
    checks++;
    if (gw_irq !== 16'h0008 || gw_irq !== m_pending) begin
      errors++; $display("FAIL level_rise: irq=%h need %h", gw_irq, m_pending);
    end
    do_claim(3);
    checks++;
    if (gw_irq[3] !== 1'b0) begin errors++; $display("FAIL level_claim: irq3=%b need 0", gw_irq[3]); end
    icb_read(8'h0C, d, v);
    checks++;
    if (v !== 1'b1 || d[3] !== 1'b1 || d[19] !== 1'b0 || d !== m_rdata) begin
      errors++; $display("FAIL level_stat: valid=%b stat=%h need 1/%h", v, d, m_rdata);
    end
    icb_write(8'h08, 32'd3);
    checks++;
    if (gw_irq[3] !== 1'b0) begin errors++; $display("FAIL level_cmp_idle: irq3=%b need 0", gw_irq[3]); end
    tick();
    checks++;
    if (gw_irq[3] !== 1'b1) begin errors++; $display("FAIL level_rerise: irq3=%b need 1", gw_irq[3]); end
  endtask

  task automatic test_edge_saturate();
    bit [31:0] d; bit v;
    do_reset();
    icb_write(8'h04, 32'h1 << 5);
    icb_write(8'h00, 32'h1 << 5);
    pulse(5);
    checks++;
    if (gw_irq[5] !== 1'b1) begin errors++; $display("FAIL edge_first: irq5=%b need 1", gw_irq[5]); end
    do_claim(5);
    repeat (4) pulse(5);
    icb_read(8'h10, d, v);
    checks++;
    if (d[9:8] !== 2'd3 || d !== m_rdata) begin
      errors++; $display("FAIL edge_cnt_sat: cnt=%h need %h (ch5 field 3)", d, m_rdata);
    end
    for (int k = 0; k < 3; k++) begin
      icb_write(8'h08, 32'd5);
      checks++;
      if (gw_irq[5] !== 1'b1) begin errors++; $display("FAIL edge_requeue_%0d: irq5=%b need 1", k, gw_irq[5]); end
      do_claim(5);
    end
    icb_write(8'h08, 32'd5);
    tick(); tick();
    icb_read(8'h0C, d, v);
    checks++;
    if (gw_irq[5] !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL edge_final_idle: irq5=%b stat=%h need 0/0", gw_irq[5], d);
    end
  endtask

  task automatic test_same_cycle();
    bit [31:0] d; bit v; int n;
    do_reset();
    icb_write(8'h04, 32'h1 << 4);
    icb_write(8'h00, 32'h1 << 4);
    pulse(4);
    do_claim(4);
    pulse(4);
    irq_src[4] = 1;
    n = 0;
    while (!(m_s2[4] && !m_sd[4]) && n < 10) begin tick(); n++; end
    checks++;
    if (n >= 10) begin errors++; $display("FAIL same_cycle_timeout: waited %0d need <10", n); end
    icb_write(8'h08, 32'd4);
    irq_src[4] = 0;
    checks++;
    if (gw_irq[4] !== 1'b1) begin errors++; $display("FAIL same_cycle_req: irq4=%b need 1", gw_irq[4]); end
    icb_read(8'h10, d, v);
    checks++;
    if (d[7:6] !== 2'd1 || d !== m_rdata) begin
      errors++; $display("FAIL same_cycle_cnt: cnt=%h need %h (ch4 field 1)", d, m_rdata);
    end
  endtask

  task automatic test_ignored();
    bit [31:0] d; bit v;
    do_reset();
    icb_write(8'h00, (32'h1 << 7) | (32'h1 << 9));
    do_claim(7);
    icb_read(8'h0C, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL claim_idle: stat=%h need 0", d); end
    irq_src[9] = 1;
    tick(); tick(); tick();
    icb_write(8'h08, 32'd9);
    checks++;
    if (gw_irq[9] !== 1'b1) begin errors++; $display("FAIL cmp_in_req: irq9=%b need 1", gw_irq[9]); end
    icb_read(8'h08, d, v);
    checks++;
    if (d !== 32'd9) begin errors++; $display("FAIL cmp_readback: got %0d need 9", d); end
    icb_write(8'h08, 32'd25);
    icb_read(8'h0C, d, v);
    checks++;
    if (d !== 32'h0200_0000) begin errors++; $display("FAIL cmp_big_id: stat=%h need 02000000", d); end
  endtask

  task automatic test_disable();
    bit [31:0] d; bit v;
    do_reset();
    icb_write(8'h04, 32'h1 << 2);
    icb_write(8'h00, 32'h1 << 2);
    pulse(2);
    do_claim(2);
    pulse(2); pulse(2);
    icb_read(8'h10, d, v);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL dis_pre_cnt: cnt=%h need 8", d); end
    icb_write(8'h00, 32'h0);
    icb_read(8'h10, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL dis_cnt: cnt=%h need 0", d); end
    icb_read(8'h0C, d, v);
    checks++;
    if (d !== 32'h0 || gw_irq !== 16'h0) begin
      errors++; $display("FAIL dis_idle: stat=%h irq=%h need 0/0", d, gw_irq);
    end
  endtask

  task automatic test_reset_mid();
    bit [31:0] d; bit v;
    do_reset();
    icb_write(8'h00, 32'h1 << 3);
    irq_src[3] = 1;
    repeat (4) tick();
    rsp_ready = 0;
    icb_read(8'h00, d, v);
    rst_n = 0;
    #1;
    checks++;
    if (gw_irq !== 16'h0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid: irq=%h valid=%b rdata=%h need 0/0/0", gw_irq, rsp_valid, rsp_rdata);
    end
    do_reset();
  endtask

  task automatic test_icb();
    bit [31:0] d, first; bit v;
    do_reset();
    icb_write(8'h00, 32'h0000_FFFF);
    icb_read(8'h14, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rd_unmapped: valid=%b data=%h need 1/0", v, d); end
    tick();
    rsp_ready = 0;
    icb_read(8'h00, first, v);
    checks++;
    if (first !== 32'h0000_FFFE) begin errors++; $display("FAIL rd_en: data=%h need 0000fffe", first); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== first) begin
        errors++; $display("FAIL rsp_hold_%0d: valid=%b data=%h need 1/%h", k, rsp_valid, rsp_rdata, first);
      end
    end
    rsp_ready = 1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_drain: valid=%b need 0", rsp_valid); end
  endtask

  task automatic test_random();
    bit [7:0] addrs [6];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 1; i < 16; i++)
        if ($urandom_range(7) == 0) irq_src[i] = ~irq_src[i];
      claim_valid = ($urandom_range(3) == 0);
      claim_id    = 5'($urandom_range(17));
      rsp_ready   = ($urandom_range(3) != 0);
      cmd_valid   = ($urandom_range(3) == 0);
      cmd_read    = $urandom_range(1) == 1;
      cmd_addr    = {24'h0, addrs[$urandom_range(5)]};
      cmd_wdata   = (cmd_addr[7:0] == 8'h08) ? 32'($urandom_range(17)) :
                    (cmd_addr[7:0] == 8'h00) ? ($urandom | 32'h0000_AAAA) : $urandom;
      tick();
      checks++;
      if (gw_irq !== m_pending || rsp_valid !== m_rv || (m_rv && rsp_rdata !== m_rdata)) begin
        errors++;
        $display("FAIL random_c%0d: irq=%h valid=%b rdata=%h need %h/%b/%h",
                 c, gw_irq, rsp_valid, rsp_rdata, m_pending, m_rv, m_rdata);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_saturate();
    test_same_cycle();
    test_ignored();
    test_disable();
    test_reset_mid();
    test_icb();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
